// File: rtl/onectr_pkg.sv
// Shared definitions for the onectr microprogram store: instruction field
// widths and offsets, the fixed-width instruction view and the load FSM states.
package onectr_pkg;

  // Widths of the PCSIZE-independent instruction fields.
  localparam int CTRL_W = 8;
  localparam int SEL_W  = 4;
  localparam int WEN_W  = 1;
  localparam int WA_W   = 4;
  localparam int RA_W   = 4;
  localparam int OP_W   = 3;
  localparam int JP_W   = 1;
  localparam int JF_W   = 1;

  // The fixed part sits above JumpAddress in every instruction word.
  localparam int FIXED_W = CTRL_W + SEL_W + WEN_W + WA_W + 2 * RA_W + OP_W + JP_W + JF_W;

  // Bit offsets inside the fixed part, LSB first.
  localparam int JF_OFF   = 0;
  localparam int JP_OFF   = JF_OFF + JF_W;
  localparam int OP_OFF   = JP_OFF + JP_W;
  localparam int RAB_OFF  = OP_OFF + OP_W;
  localparam int RAA_OFF  = RAB_OFF + RA_W;
  localparam int WA_OFF   = RAA_OFF + RA_W;
  localparam int WEN_OFF  = WA_OFF + WA_W;
  localparam int SEL_OFF  = WEN_OFF + WEN_W;
  localparam int CTRL_OFF = SEL_OFF + SEL_W;

  // Typed view of the fixed upper part of an instruction word.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [SEL_W-1:0]  sel;
    logic              wen;
    logic [WA_W-1:0]   wa;
    logic [RA_W-1:0]   raa;
    logic [RA_W-1:0]   rab;
    logic [OP_W-1:0]   op;
    logic              jp;
    logic              jf;
  } onectr_instr_t;

  // Program load FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } progmem_state_t;

  // Split the fixed part of a word into its named fields.
  function automatic onectr_instr_t unpack_instr(input logic [FIXED_W-1:0] bits);
    onectr_instr_t instr;
    instr.ctrl = bits[CTRL_OFF +: CTRL_W];
    instr.sel  = bits[SEL_OFF +: SEL_W];
    instr.wen  = bits[WEN_OFF];
    instr.wa   = bits[WA_OFF +: WA_W];
    instr.raa  = bits[RAA_OFF +: RA_W];
    instr.rab  = bits[RAB_OFF +: RA_W];
    instr.op   = bits[OP_OFF +: OP_W];
    instr.jp   = bits[JP_OFF];
    instr.jf   = bits[JF_OFF];
    return instr;
  endfunction

endpackage

// File: rtl/onectr_instr_decode.sv
// Combinational instruction decoder: slices a fetched word into its fields
// and substitutes an all-zero NOP when the entry is invalid or fetch is off.
module onectr_instr_decode
  import onectr_pkg::*;
#(
  parameter int PCSIZE = 8
) (
  input  logic [FIXED_W+PCSIZE-1:0] word,
  input  logic                      entry_valid,
  input  logic                      enable,
  output logic [CTRL_W-1:0]         ctrl,
  output logic [SEL_W-1:0]          sel,
  output logic                      wen,
  output logic [WA_W-1:0]           wa,
  output logic [RA_W-1:0]           raa,
  output logic [RA_W-1:0]           rab,
  output logic [OP_W-1:0]           op,
  output logic                      jp,
  output logic                      jf,
  output logic [PCSIZE-1:0]         jump_address
);

  onectr_instr_t instr;

  // Select the decoded word or a NOP.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    instr        = '0;
    jump_address = '0;
    if (enable && entry_valid) begin
      instr        = unpack_instr(word[FIXED_W+PCSIZE-1:PCSIZE]);
      jump_address = word[PCSIZE-1:0];
    end
  end

  assign ctrl = instr.ctrl;
  assign sel  = instr.sel;
  assign wen  = instr.wen;
  assign wa   = instr.wa;
  assign raa  = instr.raa;
  assign rab  = instr.rab;
  assign op   = instr.op;
  assign jp   = instr.jp;
  assign jf   = instr.jf;

endmodule

// File: rtl/onectr_progmem.sv
// Microprogram store for the memory-less onectr configuration. A small FSM
// loads the program from a valid/ready word stream, after which onectr's
// PCAddress is decoded combinationally into instruction fields.
module onectr_progmem
  import onectr_pkg::*;
#(
  parameter int PCSIZE = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid_i,
  output logic                      load_ready_o,
  input  logic [FIXED_W+PCSIZE-1:0] load_data_i,
  input  logic                      load_last_i,
  input  logic                      clear_i,
  output logic                      prog_ready_o,
  output logic                      err_o,
  output logic [PCSIZE:0]           load_count_o,
  input  logic [PCSIZE-1:0]         PCAddress,
  output logic [CTRL_W-1:0]         Ctrl,
  output logic [SEL_W-1:0]          Sel,
  output logic                      Wen,
  output logic [WA_W-1:0]           WA,
  output logic [RA_W-1:0]           RAA,
  output logic [RA_W-1:0]           RAB,
  output logic [OP_W-1:0]           Op,
  output logic                      JP,
  output logic                      JF,
  output logic [PCSIZE-1:0]         JumpAddress
);

  localparam int IW    = FIXED_W + PCSIZE;
  localparam int DEPTH = 2 ** PCSIZE;
  localparam logic [PCSIZE:0] CNT_MAX = (PCSIZE + 1)'(DEPTH);

  progmem_state_t    state;
  logic [IW-1:0]     mem [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  logic              load_hs;
  logic              mem_we;
  logic [PCSIZE-1:0] wr_addr;
  logic              wr_at_end;
  logic [PCSIZE:0]   cnt_inc;

  // The count is always the next free address while loading; in IDLE it is 0.
  assign load_hs   = load_valid_i && load_ready_o;
  assign wr_addr   = load_count_o[PCSIZE-1:0];
  assign wr_at_end = (wr_addr == {PCSIZE{1'b1}});
  assign cnt_inc   = (load_count_o == CNT_MAX) ? load_count_o : load_count_o + 1'b1;
  // A clear on the same edge drops the word; reset blocks writes too.
  assign mem_we    = load_hs && !clear_i && !rst;

  // Load FSM, load counter, valid bits and registered handshake/status flags.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state        <= ST_IDLE;
      valid_q      <= '0;
      load_count_o <= '0;
      err_o        <= 1'b0;
      prog_ready_o <= 1'b0;
      load_ready_o <= 1'b1;
    end else if (clear_i) begin
      state        <= ST_IDLE;
      valid_q      <= '0;
      load_count_o <= '0;
      err_o        <= 1'b0;
      prog_ready_o <= 1'b0;
      load_ready_o <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (load_hs) begin
            valid_q[wr_addr] <= 1'b1;
            load_count_o     <= cnt_inc;
            if (load_last_i || wr_at_end) begin
              // Running past the last address truncates the load and flags it.
              state        <= ST_RUN;
              err_o        <= !load_last_i;
              prog_ready_o <= 1'b1;
              load_ready_o <= 1'b0;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_RUN: begin
          prog_ready_o <= 1'b1;
          load_ready_o <= 1'b0;
        end
        default: begin
          state        <= ST_IDLE;
          valid_q      <= '0;
          load_count_o <= '0;
          err_o        <= 1'b0;
          prog_ready_o <= 1'b0;
          load_ready_o <= 1'b1;
        end
      endcase
    end
  end

  // Program storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; stale contents are masked by valid_q,
    // which keeps the storage free of per-entry reset logic.
    if (mem_we) begin
      mem[wr_addr] <= load_data_i;
    end
  end

  onectr_instr_decode #(
    .PCSIZE (PCSIZE)
  ) u_decode (
    .word         (mem[PCAddress]),
    .entry_valid  (valid_q[PCAddress]),
    .enable       (state == ST_RUN),
    .ctrl         (Ctrl),
    .sel          (Sel),
    .wen          (Wen),
    .wa           (WA),
    .raa          (RAA),
    .rab          (RAB),
    .op           (Op),
    .jp           (JP),
    .jf           (JF),
    .jump_address (JumpAddress)
  );

endmodule

// File: tb/tb_onectr_progmem.sv
// Directed testbench for onectr_progmem: a PCSIZE=8 instance for the main
// load/fetch/clear/reset sequences and a PCSIZE=2 instance for overflow.
module tb_onectr_progmem;

  logic clk;
  logic rst;

  // PCSIZE = 8 instance
  logic        ld_valid, ld_ready, ld_last, clear, prog_ready, err;
  logic [37:0] ld_data;
  logic [8:0]  ld_count;
  logic [7:0]  pc;
  logic [7:0]  ctrl;
  logic [3:0]  sel, wa, raa, rab;
  logic        wen, jp, jf;
  logic [2:0]  op;
  logic [7:0]  ja;

  // PCSIZE = 2 instance
  logic        s_valid, s_ready, s_last, s_clear, s_prog_ready, s_err;
  logic [31:0] s_data;
  logic [2:0]  s_count;
  logic [1:0]  s_pc;
  logic [7:0]  s_ctrl;
  logic [3:0]  s_sel, s_wa, s_raa, s_rab;
  logic        s_wen, s_jp, s_jf;
  logic [2:0]  s_op;
  logic [1:0]  s_ja;

  int n_checks = 0;
  int n_pass   = 0;

  onectr_progmem #(.PCSIZE(8)) dut (
    .clk(clk), .rst(rst),
    .load_valid_i(ld_valid), .load_ready_o(ld_ready), .load_data_i(ld_data),
    .load_last_i(ld_last), .clear_i(clear), .prog_ready_o(prog_ready),
    .err_o(err), .load_count_o(ld_count), .PCAddress(pc),
    .Ctrl(ctrl), .Sel(sel), .Wen(wen), .WA(wa), .RAA(raa), .RAB(rab),
    .Op(op), .JP(jp), .JF(jf), .JumpAddress(ja)
  );

  onectr_progmem #(.PCSIZE(2)) dut_small (
    .clk(clk), .rst(rst),
    .load_valid_i(s_valid), .load_ready_o(s_ready), .load_data_i(s_data),
    .load_last_i(s_last), .clear_i(s_clear), .prog_ready_o(s_prog_ready),
    .err_o(s_err), .load_count_o(s_count), .PCAddress(s_pc),
    .Ctrl(s_ctrl), .Sel(s_sel), .Wen(s_wen), .WA(s_wa), .RAA(s_raa), .RAB(s_rab),
    .Op(s_op), .JP(s_jp), .JF(s_jf), .JumpAddress(s_ja)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [37:0] mk_word(input logic [7:0] c, input logic [3:0] s,
                                          input logic w, input logic [3:0] a,
                                          input logic [3:0] ra, input logic [3:0] rb,
                                          input logic [2:0] o, input logic p,
                                          input logic f, input logic [7:0] j);
    return {c, s, w, a, ra, rb, o, p, f, j};
  endfunction

  function automatic logic [37:0] fields();
    return {ctrl, sel, wen, wa, raa, rab, op, jp, jf, ja};
  endfunction

  function automatic logic [31:0] s_fields();
    return {s_ctrl, s_sel, s_wen, s_wa, s_raa, s_rab, s_op, s_jp, s_jf, s_ja};
  endfunction

  // One load beat on the large instance; the handshake lands on the next edge.
  task automatic push(input logic [37:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  logic [37:0] w0, w1, w2, tw [4];
  logic [31:0] sw [5];

  initial begin
    rst = 1'b1;
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0; clear = 1'b0; pc = 8'd5;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_clear = 1'b0; s_pc = 2'd0;

    w0 = mk_word(8'h11, 4'h1, 1'b0, 4'h9, 4'h8, 4'h6, 3'd1, 1'b0, 1'b1, 8'h22);
    w1 = mk_word(8'hA5, 4'd3, 1'b1, 4'd2, 4'd4, 4'd7, 3'd5, 1'b1, 1'b0, 8'h10);
    w2 = mk_word(8'h5A, 4'hC, 1'b1, 4'hF, 4'h0, 4'h3, 3'd7, 1'b1, 1'b1, 8'hFE);
    tw[0] = mk_word(8'h30, 4'h0, 1'b1, 4'h1, 4'h2, 4'h3, 3'd0, 1'b0, 1'b1, 8'h40);
    tw[1] = mk_word(8'h31, 4'h1, 1'b0, 4'h2, 4'h3, 4'h4, 3'd1, 1'b1, 1'b0, 8'h41);
    tw[2] = mk_word(8'h32, 4'h2, 1'b1, 4'h3, 4'h4, 4'h5, 3'd2, 1'b0, 1'b1, 8'h42);
    tw[3] = mk_word(8'h33, 4'h3, 1'b0, 4'h4, 4'h5, 4'h6, 3'd3, 1'b1, 1'b0, 8'h43);
    sw[0] = 32'hDEAD_BEE1; sw[1] = 32'h1234_5672;
    sw[2] = 32'hCAFE_F00D; sw[3] = 32'h0F0F_0F0F; sw[4] = 32'hFFFF_FFFF;

    // Reset state with no program loaded.
    #12 rst = 1'b0;
    #1;
    check("rst_fields",     64'(fields()), 64'd0);
    check("rst_prog_ready", 64'(prog_ready), 64'd0);
    check("rst_load_ready", 64'(ld_ready), 64'd1);
    check("rst_count",      64'(ld_count), 64'd0);
    check("rst_err",        64'(err), 64'd0);

    // Three-word load, last on word 2; fields stay zero while loading.
    push(w0, 1'b0);
    pc = 8'd0;
    #1;
    check("load_fields_zero", 64'(fields()), 64'd0);
    check("load_count1",      64'(ld_count), 64'd1);
    push(w1, 1'b0);
    push(w2, 1'b1);
    check("run_prog_ready", 64'(prog_ready), 64'd1);
    check("run_load_ready", 64'(ld_ready), 64'd0);
    check("run_count3",     64'(ld_count), 64'd3);
    check("run_err",        64'(err), 64'd0);
    pc = 8'd1;
    #1;
    check("pc1_ctrl", 64'(ctrl), 64'hA5);
    check("pc1_sel",  64'(sel), 64'd3);
    check("pc1_wen",  64'(wen), 64'd1);
    check("pc1_wa",   64'(wa), 64'd2);
    check("pc1_raa",  64'(raa), 64'd4);
    check("pc1_rab",  64'(rab), 64'd7);
    check("pc1_op",   64'(op), 64'd5);
    check("pc1_jp",   64'(jp), 64'd1);
    check("pc1_jf",   64'(jf), 64'd0);
    check("pc1_ja",   64'(ja), 64'h10);
    pc = 8'd0;
    #1;
    check("pc0_word", 64'(fields()), 64'(w0));
    pc = 8'd2;
    #1;
    check("pc2_word", 64'(fields()), 64'(w2));
    pc = 8'd3;
    #1;
    check("pc3_invalid", 64'(fields()), 64'd0);

    // Clear in RUN, then a one-word reload: the old entry 1 must read as NOP.
    pulse_clear();
    pc = 8'd1;
    #1;
    check("clr_fields",     64'(fields()), 64'd0);
    check("clr_prog_ready", 64'(prog_ready), 64'd0);
    check("clr_load_ready", 64'(ld_ready), 64'd1);
    check("clr_count",      64'(ld_count), 64'd0);
    check("clr_err",        64'(err), 64'd0);
    push(w2, 1'b1);
    check("reload_count", 64'(ld_count), 64'd1);
    check("reload_stale", 64'(fields()), 64'd0);
    pc = 8'd0;
    #1;
    check("reload_pc0", 64'(fields()), 64'(w2));

    // Clear beats a simultaneous handshake in IDLE; the word is dropped.
    pulse_clear();
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = w1; clear = 1'b1;
    @(posedge clk);
    #1;
    ld_valid = 1'b0; ld_last = 1'b0; clear = 1'b0;
    check("clrpri_count",      64'(ld_count), 64'd0);
    check("clrpri_prog_ready", 64'(prog_ready), 64'd0);

    // Gapped stream: valid toggles, junk data on the idle beats, last on word 3.
    for (int i = 0; i < 8; i++) begin
      ld_valid = (i % 2 == 0);
      ld_data  = (i % 2 == 0) ? tw[i/2] : 38'h3F_FFFF_FFFF;
      ld_last  = (i == 6);
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("gap_count",      64'(ld_count), 64'd4);
    check("gap_prog_ready", 64'(prog_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      pc = 8'(i);
      #1;
      check($sformatf("gap_word%0d", i), 64'(fields()), 64'(tw[i]));
    end
    pc = 8'd4;
    #1;
    check("gap_pc4", 64'(fields()), 64'd0);

    // Reset after two of four words: immediate IDLE, then a clean reload.
    pulse_clear();
    push(tw[3], 1'b0);
    push(tw[2], 1'b0);
    check("mid_count2", 64'(ld_count), 64'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_count",      64'(ld_count), 64'd0);
    check("arst_load_ready", 64'(ld_ready), 64'd1);
    check("arst_prog_ready", 64'(prog_ready), 64'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) push(tw[i], (i == 3));
    check("post_count", 64'(ld_count), 64'd4);
    check("post_err",   64'(err), 64'd0);
    pc = 8'd1;
    #1;
    check("post_word1", 64'(fields()), 64'(tw[1]));
    pc = 8'd3;
    #1;
    check("post_word3", 64'(fields()), 64'(tw[3]));

    // PCSIZE=2: five words without last overflow after address 3.
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = sw[i];
      s_last  = 1'b0;
      @(posedge clk);
      #1;
      if (i == 3) begin
        check("ovf_err",        64'(s_err), 64'd1);
        check("ovf_prog_ready", 64'(s_prog_ready), 64'd1);
        check("ovf_count",      64'(s_count), 64'd4);
      end
    end
    s_valid = 1'b0;
    check("ovf_ready",     64'(s_ready), 64'd0);
    check("ovf_count_sat", 64'(s_count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      s_pc = 2'(i);
      #1;
      check($sformatf("ovf_word%0d", i), 64'(s_fields()), 64'(sw[i]));
    end
    s_clear = 1'b1;
    @(posedge clk);
    #1;
    s_clear = 1'b0;
    check("ovf_clr_err",    64'(s_err), 64'd0);
    check("ovf_clr_fields", 64'(s_fields()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
